// File: rtl/noc_injector.sv
// Network-interface transmitter: turns core packets into head/body/tail flits on
// one router input port, gated by per-VC credits, buffer ready and VC lock.
module noc_injector #(
  parameter int DATA_W    = 64,
  parameter int VCH_N     = 2,
  parameter int VCH_W     = 1,
  parameter int BUF_DEPTH = 4,
  parameter int ARRAY_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [DATA_W-3:0]   src_data,
  input  logic                src_last,
  input  logic [VCH_W-1:0]    src_vch,
  input  logic [ARRAY_W-1:0]  src_dst_x,
  input  logic [ARRAY_W-1:0]  src_dst_y,
  output logic [DATA_W-1:0]   odata,
  output logic                ovalid,
  output logic [VCH_W-1:0]    ovch,
  input  logic [VCH_N-1:0]    iack,
  input  logic [VCH_N-1:0]    irdy,
  input  logic [VCH_N-1:0]    ilck,
  output logic                busy,
  output logic                err
);

  localparam int CRED_W = $clog2(BUF_DEPTH + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BODY = 1'b1;

  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  logic [0:0]        state_q,   state_d;
  logic [VCH_W-1:0]  cur_vch_q, cur_vch_d;
  logic [DATA_W-1:0] odata_q,   odata_d;
  logic              ovalid_q,  ovalid_d;
  logic [VCH_W-1:0]  ovch_q,    ovch_d;
  logic              err_q,     err_d;
  logic [CRED_W-1:0] credit_q [VCH_N];
  logic [CRED_W-1:0] credit_d [VCH_N];

  logic [VCH_N-1:0]  can_send_s;
  logic              start_s;
  logic              fire_s;
  logic              send_s;
  logic [VCH_W-1:0]  send_vch_s;
  logic [DATA_W-3:0] head_payload_s;

  always_comb begin
    for (int v = 0; v < VCH_N; v++) begin
      can_send_s[v] = (credit_q[v] != '0) && irdy[v];
    end
    // In IDLE the first beat is only peeked; its vch/dst choose the head flit.
    start_s    = (state_q == S_IDLE) && src_valid && !ilck[src_vch] && can_send_s[src_vch];
    fire_s     = (state_q == S_BODY) && src_valid && can_send_s[cur_vch_q];
    send_s     = start_s || fire_s;
    send_vch_s = start_s ? src_vch : cur_vch_q;

    head_payload_s = '0;
    head_payload_s[ARRAY_W-1:0]         = src_dst_x;
    head_payload_s[2*ARRAY_W-1:ARRAY_W] = src_dst_y;
  end

  always_comb begin
    state_d   = state_q;
    cur_vch_d = cur_vch_q;
    odata_d   = odata_q;
    ovch_d    = ovch_q;
    ovalid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          state_d   = S_BODY;
          cur_vch_d = src_vch;
          odata_d   = {FT_HEAD, head_payload_s};
          ovch_d    = src_vch;
          ovalid_d  = 1'b1;
        end
      end
      S_BODY: begin
        if (fire_s) begin
          odata_d  = {(src_last ? FT_TAIL : FT_BODY), src_data};
          ovch_d   = cur_vch_q;
          ovalid_d = 1'b1;
          if (src_last) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Send and ack on the same VC cancel; an ack at full credit saturates and flags err.
  always_comb begin
    err_d = err_q;
    for (int v = 0; v < VCH_N; v++) begin
      credit_d[v] = credit_q[v];
      if (iack[v] && !(send_s && (send_vch_s == VCH_W'(v)))) begin
        if (credit_q[v] == CRED_W'(BUF_DEPTH)) begin
          err_d = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + CRED_W'(1);
        end
      end else if (!iack[v] && send_s && (send_vch_s == VCH_W'(v))) begin
        credit_d[v] = credit_q[v] - CRED_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_vch_q <= '0;
      odata_q   <= '0;
      ovalid_q  <= 1'b0;
      ovch_q    <= '0;
      err_q     <= 1'b0;
      for (int v = 0; v < VCH_N; v++) begin
        credit_q[v] <= CRED_W'(BUF_DEPTH);
      end
    end else begin
      state_q   <= state_d;
      cur_vch_q <= cur_vch_d;
      odata_q   <= odata_d;
      ovalid_q  <= ovalid_d;
      ovch_q    <= ovch_d;
      err_q     <= err_d;
      for (int v = 0; v < VCH_N; v++) begin
        credit_q[v] <= credit_d[v];
      end
    end
  end

  assign src_ready = (state_q == S_BODY) && can_send_s[cur_vch_q];
  assign odata     = odata_q;
  assign ovalid    = ovalid_q;
  assign ovch      = ovch_q;
  assign busy      = (state_q == S_BODY);
  assign err       = err_q;

endmodule

// File: tb/tb_noc_injector.sv
// Directed bench for noc_injector: flit framing, credit gating, VC lock,
// back-to-back packets and mid-packet reset, with hand-computed expectations.
module tb_noc_injector;

  logic        clk;
  logic        rst;
  logic        src_valid;
  logic        src_ready;
  logic [61:0] src_data;
  logic        src_last;
  logic [0:0]  src_vch;
  logic [2:0]  src_dst_x;
  logic [2:0]  src_dst_y;
  logic [63:0] odata;
  logic        ovalid;
  logic [0:0]  ovch;
  logic [1:0]  iack;
  logic [1:0]  irdy;
  logic [1:0]  ilck;
  logic        busy;
  logic        err;

  int total;
  int passed;

  noc_injector dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_data  (src_data),
    .src_last  (src_last),
    .src_vch   (src_vch),
    .src_dst_x (src_dst_x),
    .src_dst_y (src_dst_y),
    .odata     (odata),
    .ovalid    (ovalid),
    .ovch      (ovch),
    .iack      (iack),
    .irdy      (irdy),
    .ilck      (ilck),
    .busy      (busy),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic beat(input logic [0:0] vch, input logic [2:0] x, input logic [2:0] y,
                      input logic [61:0] d, input logic last);
    src_valid = 1'b1;
    src_vch   = vch;
    src_dst_x = x;
    src_dst_y = y;
    src_data  = d;
    src_last  = last;
  endtask

  task automatic acks(input logic [1:0] mask, input int n);
    iack = mask;
    for (int i = 0; i < n; i++) step();
    iack = 2'b00;
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1; src_valid = 1'b0; src_data = 62'h0; src_last = 1'b0;
    src_vch = 1'b0; src_dst_x = 3'd0; src_dst_y = 3'd0;
    iack = 2'b00; irdy = 2'b11; ilck = 2'b00;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_ovalid", {63'd0, ovalid}, 64'd0);
    chk("rst_odata", odata, 64'd0);
    chk("rst_ovch", {63'd0, ovch}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_ready", {63'd0, src_ready}, 64'd0);
    chk("rst_cred0", {61'd0, dut.credit_q[0]}, 64'd4);
    chk("rst_cred1", {61'd0, dut.credit_q[1]}, 64'd4);

    // 1-beat packet on VC1, dst (2,5)
    beat(1'b1, 3'd2, 3'd5, 62'hABC, 1'b1);
    #1;
    chk("t1_ready_idle", {63'd0, src_ready}, 64'd0);
    step();
    chk("t1_head_valid", {63'd0, ovalid}, 64'd1);
    chk("t1_head_data", odata, 64'h4000_0000_0000_002A);
    chk("t1_head_vch", {63'd0, ovch}, 64'd1);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    chk("t1_ready_body", {63'd0, src_ready}, 64'd1);
    step();
    src_valid = 1'b0;
    chk("t1_tail_valid", {63'd0, ovalid}, 64'd1);
    chk("t1_tail_data", odata, 64'hC000_0000_0000_0ABC);
    chk("t1_busy_done", {63'd0, busy}, 64'd0);
    chk("t1_cred1", {61'd0, dut.credit_q[1]}, 64'd2);
    step();
    chk("t1_idle_valid", {63'd0, ovalid}, 64'd0);
    chk("t1_odata_hold", odata, 64'hC000_0000_0000_0ABC);
    acks(2'b10, 2);
    chk("t1_cred1_back", {61'd0, dut.credit_q[1]}, 64'd4);

    // 4-beat packet on VC0 with credit exhaustion
    beat(1'b0, 3'd1, 3'd3, 62'h111, 1'b0);
    step();
    chk("t2_head", odata, 64'h4000_0000_0000_0019);
    chk("t2_head_vch", {63'd0, ovch}, 64'd0);
    step();
    chk("t2_b1", odata, 64'h8000_0000_0000_0111);
    src_data = 62'h222;
    step();
    chk("t2_b2", odata, 64'h8000_0000_0000_0222);
    src_data = 62'h333;
    step();
    chk("t2_b3", odata, 64'h8000_0000_0000_0333);
    chk("t2_b3_valid", {63'd0, ovalid}, 64'd1);
    src_data = 62'h444; src_last = 1'b1;
    #1;
    chk("t2_stall_ready", {63'd0, src_ready}, 64'd0);
    step();
    chk("t2_stall_valid", {63'd0, ovalid}, 64'd0);
    chk("t2_stall_busy", {63'd0, busy}, 64'd1);
    step();
    chk("t2_stall_valid2", {63'd0, ovalid}, 64'd0);
    acks(2'b01, 1);
    chk("t2_ack_valid", {63'd0, ovalid}, 64'd0);
    chk("t2_ack_ready", {63'd0, src_ready}, 64'd1);
    step();
    src_valid = 1'b0;
    chk("t2_tail_valid", {63'd0, ovalid}, 64'd1);
    chk("t2_tail", odata, 64'hC000_0000_0000_0444);
    chk("t2_tail_busy", {63'd0, busy}, 64'd0);
    step();
    chk("t2_one_tail", {63'd0, ovalid}, 64'd0);
    acks(2'b01, 4);
    chk("t2_cred0_back", {61'd0, dut.credit_q[0]}, 64'd4);
    chk("t2_err", {63'd0, err}, 64'd0);

    // VC lock holds the head; lock mid-packet is ignored
    ilck = 2'b10;
    beat(1'b1, 3'd7, 3'd7, 62'h55, 1'b0);
    step(); step(); step();
    chk("t3_locked_valid", {63'd0, ovalid}, 64'd0);
    chk("t3_locked_busy", {63'd0, busy}, 64'd0);
    ilck = 2'b00;
    step();
    chk("t3_head_valid", {63'd0, ovalid}, 64'd1);
    chk("t3_head", odata, 64'h4000_0000_0000_003F);
    chk("t3_head_vch", {63'd0, ovch}, 64'd1);
    ilck = 2'b10;
    step();
    chk("t3_body_locked", odata, 64'h8000_0000_0000_0055);
    chk("t3_body_valid", {63'd0, ovalid}, 64'd1);
    src_data = 62'h66; src_last = 1'b1;
    step();
    chk("t3_tail", odata, 64'hC000_0000_0000_0066);
    src_valid = 1'b0; ilck = 2'b00;
    acks(2'b10, 3);
    chk("t3_cred1_back", {61'd0, dut.credit_q[1]}, 64'd4);

    // Simultaneous send+ack, then overflow ack
    beat(1'b0, 3'd0, 3'd0, 62'h1, 1'b0);
    step();
    step();
    chk("t4_cred0_2", {61'd0, dut.credit_q[0]}, 64'd2);
    src_data = 62'h2; src_last = 1'b1; iack = 2'b01;
    step();
    iack = 2'b00; src_valid = 1'b0;
    chk("t4_send_ack_cred", {61'd0, dut.credit_q[0]}, 64'd2);
    chk("t4_send_ack_tail", odata, 64'hC000_0000_0000_0002);
    acks(2'b01, 2);
    chk("t4_cred0_full", {61'd0, dut.credit_q[0]}, 64'd4);
    chk("t4_err_before", {63'd0, err}, 64'd0);
    acks(2'b01, 1);
    chk("t4_ovf_cred", {61'd0, dut.credit_q[0]}, 64'd4);
    chk("t4_ovf_err", {63'd0, err}, 64'd1);
    step(); step();
    chk("t4_err_sticky", {63'd0, err}, 64'd1);

    // Back-to-back packets VC0 then VC1, no bubble
    beat(1'b0, 3'd1, 3'd1, 62'hA1, 1'b0);
    step();
    chk("t5_a_head", odata, 64'h4000_0000_0000_0009);
    step();
    chk("t5_a_body", odata, 64'h8000_0000_0000_00A1);
    src_data = 62'hA2; src_last = 1'b1;
    step();
    chk("t5_a_tail", odata, 64'hC000_0000_0000_00A2);
    chk("t5_a_tail_vch", {63'd0, ovch}, 64'd0);
    beat(1'b1, 3'd2, 3'd2, 62'hB1, 1'b0);
    step();
    chk("t5_b_head_valid", {63'd0, ovalid}, 64'd1);
    chk("t5_b_head", odata, 64'h4000_0000_0000_0012);
    chk("t5_b_head_vch", {63'd0, ovch}, 64'd1);
    step();
    chk("t5_b_body_valid", {63'd0, ovalid}, 64'd1);
    chk("t5_b_body", odata, 64'h8000_0000_0000_00B1);
    src_data = 62'hB2; src_last = 1'b1;
    step();
    src_valid = 1'b0;
    chk("t5_b_tail", odata, 64'hC000_0000_0000_00B2);
    chk("t5_b_tail_vch", {63'd0, ovch}, 64'd1);
    acks(2'b11, 3);
    chk("t5_cred0", {61'd0, dut.credit_q[0]}, 64'd4);
    chk("t5_cred1", {61'd0, dut.credit_q[1]}, 64'd4);

    // Reset mid-packet, then a clean restart
    beat(1'b0, 3'd3, 3'd4, 62'h77, 1'b0);
    step();
    step();
    chk("t6_body", odata, 64'h8000_0000_0000_0077);
    rst = 1'b1;
    step();
    chk("t6_rst_valid", {63'd0, ovalid}, 64'd0);
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_cred0", {61'd0, dut.credit_q[0]}, 64'd4);
    chk("t6_rst_err", {63'd0, err}, 64'd0);
    rst = 1'b0;
    src_data = 62'h88; src_last = 1'b1;
    step();
    chk("t6_new_head_valid", {63'd0, ovalid}, 64'd1);
    chk("t6_new_head", odata, 64'h4000_0000_0000_0023);
    step();
    src_valid = 1'b0;
    chk("t6_new_tail", odata, 64'hC000_0000_0000_0088);
    step();
    chk("t6_idle", {63'd0, ovalid}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
